bus_arbiter: RTL and testbench

//  Two-port request arbiter sitting directly upstream of bus_master. It accepts

---
 rtl/bus_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port request arbiter in front of bus_master: buffers one request per port,
// issues them one at a time on the start/ready handshake, and routes completion back.
module bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] p0_addr,
    input  logic        p0_start,
    input  logic        p0_write,
    input  logic [31:0] p0_data_rw,
    output logic        p0_ready,
    output logic [31:0] p0_data_rd,
    input  logic [29:0] p1_addr,
    input  logic        p1_start,
    input  logic        p1_write,
    input  logic [31:0] p1_data_rw,
    output logic        p1_ready,
    output logic [31:0] p1_data_rd,
    output logic [29:0] m_addr,
    output logic        m_start,
    output logic        m_write,
    output logic [31:0] m_data_rw,
    input  logic        m_ready,
    input  logic [31:0] m_data_rd,
    output logic        err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic        grant;
    logic        last;
    logic [1:0]  pend;
    logic [1:0]  start;
    logic [1:0]  ready;
    logic [1:0]  accept;
    logic [1:0]  req;
    logic        viol;
    logic        win;

    logic [29:0] in_addr   [2];
    logic [1:0]  in_write;
    logic [31:0] in_data   [2];
    logic [29:0] slot_addr [2];
    logic [1:0]  slot_write;
    logic [31:0] slot_data [2];

    assign start      = {p1_start, p0_start};
    assign in_addr[0] = p0_addr;
    assign in_addr[1] = p1_addr;
    assign in_write   = {p1_write, p0_write};
    assign in_data[0] = p0_data_rw;
    assign in_data[1] = p1_data_rw;

    assign ready[0] = m_ready & (state == S_WAIT) & ~grant;
    assign ready[1] = m_ready & (state == S_WAIT) & grant;

    assign p0_ready   = ready[0];
    assign p1_ready   = ready[1];
    assign p0_data_rd = m_data_rd;
    assign p1_data_rd = m_data_rd;

    // A port may re-request in the very cycle its previous transaction completes.
    assign accept = start & (~pend | ready);
    assign viol   = |(start & pend & ~ready);

    // Fresh starts are visible to the idle arbiter, saving a cycle of latency.
    assign req = pend | accept;

    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = FIXED_PRIO ? 1'b0 : ~last;
        end else begin
            win = req[1];
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (accept[n]) begin
                slot_addr[n]  <= in_addr[n];
                slot_write[n] <= in_write[n];
                slot_data[n]  <= in_data[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pend      <= 2'b00;
            last      <= 1'b1;
            grant     <= 1'b0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_write   <= 1'b0;
            m_data_rw <= '0;
            err       <= 1'b0;
        end else begin
            pend <= (pend & ~ready) | accept;
            err  <= err | viol;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        m_start   <= 1'b1;
                        m_addr    <= pend[win] ? slot_addr[win]  : in_addr[win];
                        m_write   <= pend[win] ? slot_write[win] : in_write[win];
                        m_data_rw <= pend[win] ? slot_data[win]  : in_data[win];
                        grant     <= win;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    m_start <= 1'b0;
                    if (m_ready) begin
                        last  <= grant;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance share the port
// stimulus, each with its own bus responder, checked every cycle against a request-level model.
module tb_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [29:0] addr_i  [2];
    logic        start_i [2];
    logic        write_i [2];
    logic [31:0] wdata_i [2];

    logic        m_ready [2];
    logic [31:0] m_rd    [2];
    logic        rdy     [2][2];
    logic [31:0] prd     [2][2];
    logic [29:0] maddr   [2];
    logic        mstart  [2];
    logic        mwrite  [2];
    logic [31:0] mdata   [2];
    logic        errv    [2];

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .p0_addr(addr_i[0]), .p0_start(start_i[0]), .p0_write(write_i[0]), .p0_data_rw(wdata_i[0]),
        .p0_ready(rdy[0][0]), .p0_data_rd(prd[0][0]),
        .p1_addr(addr_i[1]), .p1_start(start_i[1]), .p1_write(write_i[1]), .p1_data_rw(wdata_i[1]),
        .p1_ready(rdy[0][1]), .p1_data_rd(prd[0][1]),
        .m_addr(maddr[0]), .m_start(mstart[0]), .m_write(mwrite[0]), .m_data_rw(mdata[0]),
        .m_ready(m_ready[0]), .m_data_rd(m_rd[0]), .err(errv[0])
    );

    bus_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .p0_addr(addr_i[0]), .p0_start(start_i[0]), .p0_write(write_i[0]), .p0_data_rw(wdata_i[0]),
        .p0_ready(rdy[1][0]), .p0_data_rd(prd[1][0]),
        .p1_addr(addr_i[1]), .p1_start(start_i[1]), .p1_write(write_i[1]), .p1_data_rw(wdata_i[1]),
        .p1_ready(rdy[1][1]), .p1_data_rd(prd[1][1]),
        .m_addr(maddr[1]), .m_start(mstart[1]), .m_write(mwrite[1]), .m_data_rw(mdata[1]),
        .m_ready(m_ready[1]), .m_data_rd(m_rd[1]), .err(errv[1])
    );

    // Reference model: one outstanding bus transaction plus one buffered request per port.
    bit          busy  [2];
    bit          mgrant[2];
    bit          mlast [2];
    bit          merr  [2];
    bit          mpend [2][2];
    bit [29:0]   s_addr[2][2];
    bit          s_wr  [2][2];
    bit [31:0]   s_data[2][2];
    bit          e_start[2];
    bit [29:0]   e_addr [2];
    bit          e_write[2];
    bit [31:0]   e_data [2];

    task automatic mreset(int d);
        busy[d] = 0; mgrant[d] = 0; mlast[d] = 1; merr[d] = 0;
        mpend[d][0] = 0; mpend[d][1] = 0;
        e_start[d] = 0; e_addr[d] = '0; e_write[d] = 0; e_data[d] = '0;
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit acc [2];
            bit rq  [2];
            int w;
            if (!rst) begin
                mreset(d);
                continue;
            end
            for (int n = 0; n < 2; n++) begin
                bit done_n;
                done_n = busy[d] && m_ready[d] && (int'(mgrant[d]) == n);
                acc[n] = start_i[n] && (!mpend[d][n] || done_n);
                if (start_i[n] && !acc[n]) merr[d] = 1;
            end
            if (!busy[d]) begin
                rq[0] = mpend[d][0] || acc[0];
                rq[1] = mpend[d][1] || acc[1];
                if (rq[0] || rq[1]) begin
                    if (rq[0] && rq[1]) w = (d == 1) ? 0 : (mlast[d] ? 0 : 1);
                    else                w = rq[1] ? 1 : 0;
                    e_addr[d]  = mpend[d][w] ? s_addr[d][w] : addr_i[w];
                    e_write[d] = mpend[d][w] ? s_wr[d][w]   : write_i[w];
                    e_data[d]  = mpend[d][w] ? s_data[d][w] : wdata_i[w];
                    e_start[d] = 1;
                    busy[d]    = 1;
                    mgrant[d]  = w[0];
                end
            end else begin
                e_start[d] = 0;
                if (m_ready[d]) begin
                    busy[d] = 0;
                    mlast[d] = mgrant[d];
                    mpend[d][mgrant[d]] = 0;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    mpend[d][n] = 1;
                    s_addr[d][n] = addr_i[n];
                    s_wr[d][n]   = write_i[n];
                    s_data[d][n] = wdata_i[n];
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        mreset(0);
        mreset(1);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_m_start", d), 32'(mstart[d]), 32'(e_start[d]));
                chk($sformatf("d%0d_m_addr", d), 32'(maddr[d]), 32'(e_addr[d]));
                chk($sformatf("d%0d_m_write", d), 32'(mwrite[d]), 32'(e_write[d]));
                chk($sformatf("d%0d_m_data_rw", d), mdata[d], e_data[d]);
                chk($sformatf("d%0d_err", d), 32'(errv[d]), 32'(merr[d]));
                for (int n = 0; n < 2; n++) begin
                    bit er;
                    er = rst && busy[d] && m_ready[d] && (int'(mgrant[d]) == n);
                    chk($sformatf("d%0d_p%0d_ready", d, n), 32'(rdy[d][n]), 32'(er));
                    if (er) chk($sformatf("d%0d_p%0d_data_rd", d, n), prd[d][n], m_rd[d]);
                end
            end
        end
    end

    // Bus responder: manual in directed tests, randomized latency otherwise.
    bit auto_mode = 0;
    int cnt [2];

    task automatic tick();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) start_i[n] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = $urandom;
            m_ready[d] = 1'b0;
            if (auto_mode) begin
                if (cnt[d] > 0) begin
                    cnt[d]--;
                    if (cnt[d] == 0) m_ready[d] = 1'b1;
                end else if (mstart[d]) begin
                    cnt[d] = $urandom_range(1, 4);
                end else if ($urandom_range(0, 15) == 0) begin
                    m_ready[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic async_reset();
        rst = 1'b0;
        mreset(0);
        mreset(1);
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0;
            m_ready[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        tick();
        async_reset();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic req(int n, logic [29:0] a, logic w, logic [31:0] dat);
        start_i[n] = 1'b1;
        addr_i[n]  = a;
        write_i[n] = w;
        wdata_i[n] = dat;
    endtask

    task automatic both_ready(logic [31:0] dat);
        m_ready[0] = 1'b1; m_ready[1] = 1'b1;
        m_rd[0] = dat;     m_rd[1] = dat;
    endtask

    initial begin
        logic [29:0] held_addr;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            addr_i[n] = '0; start_i[n] = 0; write_i[n] = 0; wdata_i[n] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 0; m_rd[d] = '0; cnt[d] = 0;
        end
        tick();
        @(negedge clk);
        chk("reset_m_start", 32'(mstart[0]), 32'd0);
        chk("reset_err", 32'(errv[0]), 32'd0);
        chk("reset_m_addr", 32'(maddr[1]), 32'd0);
        tick();
        rst = 1'b1;

        // Single read on p0 with one-cycle issue latency.
        do_reset();
        tick(); req(0, 30'h10, 1'b0, 32'h0);
        tick(); @(negedge clk);
        chk("t1_m_start", 32'(mstart[0]), 32'd1);
        chk("t1_m_addr", 32'(maddr[0]), 32'h10);
        chk("t1_m_write", 32'(mwrite[0]), 32'd0);
        tick(); both_ready(32'hDEADBEEF); @(negedge clk);
        chk("t1_p0_ready", 32'(rdy[0][0]), 32'd1);
        chk("t1_p0_data_rd", prd[0][0], 32'hDEADBEEF);
        chk("t1_p1_ready", 32'(rdy[0][1]), 32'd0);

        // Simultaneous starts, then p0 re-requests as it completes.
        do_reset();
        tick(); req(0, 30'h100, 1'b0, 32'h0); req(1, 30'h200, 1'b0, 32'h0);
        tick(); @(negedge clk);
        chk("t2_rr_first", 32'(maddr[0]), 32'h100);
        chk("t2_fp_first", 32'(maddr[1]), 32'h100);
        tick(); both_ready(32'h1); req(0, 30'h101, 1'b0, 32'h0);
        tick();
        tick(); @(negedge clk);
        chk("t2_rr_second", 32'(maddr[0]), 32'h200);
        chk("t2_fp_second", 32'(maddr[1]), 32'h101);
        tick(); both_ready(32'h2);
        tick();
        tick(); @(negedge clk);
        chk("t2_rr_third", 32'(maddr[0]), 32'h101);
        chk("t2_fp_third", 32'(maddr[1]), 32'h200);
        chk("t2_err", 32'(errv[0]), 32'd0);
        tick(); both_ready(32'h3);

        // p1 write queued behind an in-flight p0 read.
        do_reset();
        tick(); req(0, 30'h20, 1'b0, 32'h0);
        tick();
        tick(); req(1, 30'h30, 1'b1, 32'h55AA55AA);
        tick();
        tick(); both_ready(32'h4);
        tick(); @(negedge clk);
        chk("t3_gap_start", 32'(mstart[0]), 32'd0);
        tick(); @(negedge clk);
        chk("t3_m_start", 32'(mstart[0]), 32'd1);
        chk("t3_m_addr", 32'(maddr[0]), 32'h30);
        chk("t3_m_write", 32'(mwrite[0]), 32'd1);
        chk("t3_m_data_rw", mdata[0], 32'h55AA55AA);
        tick(); both_ready(32'h5);

        // Legal re-request on ready, then an illegal one.
        do_reset();
        tick(); req(0, 30'h40, 1'b0, 32'h0);
        tick();
        tick(); both_ready(32'h6); req(0, 30'h44, 1'b1, 32'h44); @(negedge clk);
        chk("t4_p0_ready", 32'(rdy[0][0]), 32'd1);
        tick();
        tick(); @(negedge clk);
        chk("t4_reissue_start", 32'(mstart[0]), 32'd1);
        chk("t4_reissue_addr", 32'(maddr[0]), 32'h44);
        chk("t4_err_legal", 32'(errv[0]), 32'd0);
        tick(); req(0, 30'h48, 1'b0, 32'h48);
        tick(); @(negedge clk);
        chk("t4_err_set", 32'(errv[0]), 32'd1);
        tick(); both_ready(32'h7);
        tick();
        tick(); @(negedge clk);
        chk("t4_no_issue", 32'(mstart[0]), 32'd0);
        chk("t4_addr_kept", 32'(maddr[0]), 32'h44);

        // Asynchronous reset while waiting on the bus.
        do_reset();
        tick(); req(0, 30'h50, 1'b1, 32'hA5A5A5A5);
        tick();
        tick();
        async_reset();
        #1;
        chk("t5_m_start", 32'(mstart[0]), 32'd0);
        chk("t5_m_addr", 32'(maddr[0]), 32'd0);
        chk("t5_m_write", 32'(mwrite[0]), 32'd0);
        chk("t5_m_data_rw", mdata[0], 32'd0);
        tick();
        rst = 1'b1;
        tick(); both_ready(32'h8); @(negedge clk);
        chk("t5_no_p0_ready", 32'(rdy[0][0]), 32'd0);
        chk("t5_no_p1_ready", 32'(rdy[0][1]), 32'd0);

        // Long wait: issue signals must hold steady.
        do_reset();
        tick(); req(1, 30'h3FFFFFFF, 1'b1, 32'h12345678);
        tick(); @(negedge clk);
        chk("t6_m_start", 32'(mstart[0]), 32'd1);
        held_addr = 30'h3FFFFFFF;
        for (int i = 0; i < 20; i++) begin
            tick(); @(negedge clk);
            chk("t6_start_low", 32'(mstart[0]), 32'd0);
            chk("t6_addr_hold", 32'(maddr[0]), 32'(held_addr));
            chk("t6_write_hold", 32'(mwrite[0]), 32'd1);
        end
        tick(); both_ready(32'h9); @(negedge clk);
        chk("t6_p1_ready", 32'(rdy[0][1]), 32'd1);

        // Randomized traffic with occasional mid-operation resets.
        do_reset();
        auto_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                rst = 1'b1;
                for (int n = 0; n < 2; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req(n, 30'($urandom), 1'($urandom), $urandom);
                    end
                end
            end
        end
        tick();
        rst = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
